// File: rtl/wb_arbiter.sv
// Register-file write arbiter: main writeback beats a 2-entry long-latency FIFO, with bypass and busy scoreboard.
// One-cycle write latency; lu_ready drops at full FIFO, wb_stall requests upstream relief after starvation.
module wb_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_reg_i,
  input  logic [31:0] wb_data_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_reg_i,
  input  logic [31:0] lu_data_i,
  output logic        lu_ready_o,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_reg_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  output logic        rs_busy_o,
  output logic        rt_busy_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        wb_stall_o,
  output logic [1:0]  fifo_count_o
);

  logic [4:0]  fifo_reg_q  [2];
  logic [31:0] fifo_data_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] busy_q, busy_d;
  logic [2:0]  starve_q, starve_d;
  logic        stall_q, stall_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic        wb_sel, lu_xfer, lu_live, pop, bypass, push;
  logic [4:0]  head_reg;
  logic [31:0] head_data;

  assign lu_ready_o   = (count_q < 2'd2);
  assign head_reg     = fifo_reg_q[rd_ptr_q];
  assign head_data    = fifo_data_q[rd_ptr_q];

  assign wb_sel  = wb_valid_i && (wb_reg_i != 5'd0);
  assign lu_xfer = lu_valid_i && lu_ready_o;
  // Transfers to r0 are consumed but otherwise ignored.
  assign lu_live = lu_xfer && (lu_reg_i != 5'd0);
  assign pop     = !wb_sel && (count_q != 2'd0);
  assign bypass  = !wb_sel && (count_q == 2'd0) && lu_live;
  assign push    = lu_live && !bypass;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;
    starve_d   = starve_q;
    stall_d    = stall_q;

    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;

    if (wb_sel) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_reg_i;
      rf_wdata_d = wb_data_i;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_reg;
      rf_wdata_d = head_data;
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lu_reg_i;
      rf_wdata_d = lu_data_i;
    end

    // Clear on load into the output register; a same-cycle issue wins.
    if (pop)    busy_d[head_reg] = 1'b0;
    if (bypass) busy_d[lu_reg_i] = 1'b0;
    if (issue_valid_i && (issue_reg_i != 5'd0)) busy_d[issue_reg_i] = 1'b1;
    busy_d[0] = 1'b0;

    if (pop || (count_q == 2'd0)) starve_d = 3'd0;
    else if (wb_sel && (starve_q != 3'd7)) starve_d = starve_q + 3'd1;

    if (pop) stall_d = 1'b0;
    else if (starve_d == 3'd4) stall_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      busy_q     <= 32'd0;
      starve_q   <= 3'd0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= lu_reg_i;
      fifo_data_q[wr_ptr_q] <= lu_data_i;
    end
  end

  assign rs_busy_o    = busy_q[rs_addr_i];
  assign rt_busy_o    = busy_q[rt_addr_i];
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign wb_stall_o   = stall_q;
  assign fifo_count_o = count_q;

endmodule
